// File: rtl/ahb_spi_pkg.sv
// Shared constants, register map and FSM type for the ahb_spi AHB-Lite SPI master.
package ahb_spi_pkg;

  localparam int unsigned CLK_DIV = 8;
  localparam int unsigned NUM_SS  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Byte offsets of the four word registers
  localparam logic [3:0] OFS_CTRL = 4'h0;
  localparam logic [3:0] OFS_SS   = 4'h4;
  localparam logic [3:0] OFS_TX   = 4'h8;
  localparam logic [3:0] OFS_RX   = 4'hC;

  // CTRL/STATUS bit positions
  localparam int unsigned ST_RX_FULL = 0;
  localparam int unsigned ST_BUSY    = 1;
  localparam int unsigned ST_OVERRUN = 2;
  localparam int unsigned ST_TX_DONE = 4;
  localparam int unsigned ST_MODE    = 6;
  localparam int unsigned ST_LOOP    = 7;
  localparam int unsigned ST_NB_LSB  = 12;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } spi_state_e;

  function automatic logic [1:0] reg_idx(input logic [3:0] ofs);
    return ofs[3:2];
  endfunction

endpackage

// File: rtl/ahb_spi_if.sv
// AHB-Lite slave port bundle for ahb_spi.
interface ahb_spi_if;
  import ahb_spi_pkg::*;

  logic              HSEL;
  logic              HREADY;
  logic [31:0]       HADDR;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [1:0]        HTRANS;
  logic [DATA_W-1:0] HWDATA;
  logic [DATA_W-1:0] HRDATA;
  logic              HREADYOUT;

  modport master (
    output HSEL, HREADY, HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
    input  HRDATA, HREADYOUT
  );

  modport slave (
    input  HSEL, HREADY, HADDR, HWRITE, HSIZE, HTRANS, HWDATA,
    output HRDATA, HREADYOUT
  );
endinterface

// File: rtl/spi_shifter.sv
// SPI mode-0 frame engine: SCLK divider, bit counter, TX/RX shift registers, done pulses.
module spi_shifter
  import ahb_spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [DATA_W-1:0] i_data,
  input  logic [2:0]        i_nbytes,
  input  logic              i_miso,
  output logic              o_sclk,
  output logic              o_mosi,
  output logic              o_busy_c,
  output logic              o_done_c,
  output logic              o_byte_done_c,
  output logic [DATA_W-1:0] o_rx
);

  spi_state_e        r_state;
  spi_state_e        w_state_nxt;
  logic [DIV_W-1:0]  r_div;
  logic [4:0]        r_bit;
  logic [2:0]        r_nb;
  logic [DATA_W-1:0] r_tx;

  logic              w_tick;
  logic              w_rise;
  logic              w_fall;
  logic [4:0]        w_last;
  logic [5:0]        w_shamt;
  logic [DATA_W-1:0] w_aligned;

  // Left-justify the N-byte payload so the first bit always sits in the MSB
  assign w_shamt   = 6'(6'd32 - {i_nbytes, 3'b000});
  assign w_aligned = i_data << w_shamt;

  assign w_tick = (r_div == DIV_W'(CLK_DIV - 1));
  assign w_rise = (r_state == S_SHIFT) && w_tick && !o_sclk;
  assign w_fall = (r_state == S_SHIFT) && w_tick && o_sclk;
  assign w_last = 5'({r_nb, 3'b000} - 6'd1);

  assign o_busy_c      = (r_state == S_SHIFT);
  assign o_done_c      = w_fall && (r_bit == w_last);
  assign o_byte_done_c = w_rise && (r_bit[2:0] == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (o_done_c) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: MOSI moves on falling SCLK, MISO is sampled on rising SCLK
  always_ff @(posedge clk) begin
    if (rst) begin
      r_div  <= '0;
      r_bit  <= '0;
      r_nb   <= 3'd4;
      r_tx   <= '0;
      o_sclk <= 1'b0;
      o_mosi <= 1'b0;
      o_rx   <= '0;
    end else if (r_state == S_IDLE) begin
      r_div  <= '0;
      r_bit  <= '0;
      o_sclk <= 1'b0;
      if (i_start) begin
        r_nb   <= i_nbytes;
        r_tx   <= w_aligned;
        o_mosi <= w_aligned[DATA_W-1];
      end
    end else begin
      r_div <= w_tick ? '0 : r_div + DIV_W'(1);
      if (w_tick) o_sclk <= ~o_sclk;
      if (w_rise) o_rx <= {o_rx[DATA_W-2:0], i_miso};
      if (w_fall) begin
        r_bit  <= r_bit + 5'd1;
        r_tx   <= r_tx << 1;
        o_mosi <= r_tx[DATA_W-2];
      end
    end
  end

endmodule

// File: rtl/ahb_spi.sv
// AHB-Lite slave SPI master: register file, slave selects and status flags.
// Optional feature macro: AHB_SPI_LOOPBACK_EN (internal MOSI->MISO loopback via CTRL[7]).
module ahb_spi
  import ahb_spi_pkg::*;
(
  input  logic              HCLK,
  input  logic              HRESET,
  ahb_spi_if.slave          bus,
  input  logic              SPI_MISO_i,
  output logic              SPI_MOSI_o,
  output logic [NUM_SS-1:0] SPI_SS_o,
  output logic              SPI_CLK_o
);

  localparam logic [1:0] A_CTRL = reg_idx(OFS_CTRL);
  localparam logic [1:0] A_SS   = reg_idx(OFS_SS);
  localparam logic [1:0] A_TX   = reg_idx(OFS_TX);
  localparam logic [1:0] A_RX   = reg_idx(OFS_RX);

  logic              r_dp_valid;
  logic              r_dp_write;
  logic [1:0]        r_dp_addr;
  logic [2:0]        r_nbytes;
  logic              r_mode;
  logic [NUM_SS-1:0] r_ss;
  logic              r_done;
  logic              r_overrun;
  logic              r_rx_full;
  logic [2:0]        r_rx_cnt;

  logic              w_acc;
  logic              w_wr;
  logic              w_rd;
  logic              w_ctrl_wr;
  logic              w_ss_wr;
  logic              w_tx_wr;
  logic              w_rx_rd;
  logic              w_start;
  logic              w_busy;
  logic              w_done;
  logic              w_byte;
  logic              w_loop;
  logic              w_miso;
  logic [2:0]        w_nb_dec;
  logic [DATA_W-1:0] w_rx;
  logic [DATA_W-1:0] w_rdata;
  logic              w_unused;

  assign w_unused = ^{bus.HADDR[31:4], bus.HADDR[1:0], bus.HTRANS[0], bus.HSIZE};

  assign w_acc = bus.HSEL & bus.HTRANS[1] & bus.HREADY;

  // Address phase capture; the action happens in the following data phase
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= '0;
    end else begin
      r_dp_valid <= w_acc;
      r_dp_write <= bus.HWRITE;
      r_dp_addr  <= bus.HADDR[3:2];
    end
  end

  assign w_wr      = r_dp_valid & r_dp_write;
  assign w_rd      = r_dp_valid & ~r_dp_write;
  assign w_ctrl_wr = w_wr && (r_dp_addr == A_CTRL);
  assign w_ss_wr   = w_wr && (r_dp_addr == A_SS);
  assign w_tx_wr   = w_wr && (r_dp_addr == A_TX);
  assign w_rx_rd   = w_rd && (r_dp_addr == A_RX);
  assign w_start   = w_tx_wr & ~w_busy;

  always_comb begin
    w_nb_dec = 3'd4;
    case (bus.HWDATA[ST_NB_LSB +: 4])
      4'd1:    w_nb_dec = 3'd1;
      4'd2:    w_nb_dec = 3'd2;
      4'd3:    w_nb_dec = 3'd3;
      default: w_nb_dec = 3'd4;
    endcase
  end

  // Control registers and sticky flags; a set in the same cycle as a clear wins
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_nbytes  <= 3'd4;
      r_mode    <= 1'b1;
      r_ss      <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      r_rx_full <= 1'b0;
      r_rx_cnt  <= '0;
    end else begin
      if (w_ctrl_wr) begin
        r_nbytes <= w_nb_dec;
        r_mode   <= bus.HWDATA[ST_MODE];
      end
      if (w_ss_wr) r_ss <= bus.HWDATA[NUM_SS-1:0];

      if (w_done)                  r_done <= 1'b1;
      else if (w_start || w_rx_rd) r_done <= 1'b0;

      if (w_tx_wr && w_busy) r_overrun <= 1'b1;
      else if (w_rx_rd)      r_overrun <= 1'b0;

      if (w_byte && (r_rx_cnt == 3'd3)) r_rx_full <= 1'b1;
      else if (w_rx_rd)                 r_rx_full <= 1'b0;

      if (w_rx_rd)                            r_rx_cnt <= w_byte ? 3'd1 : 3'd0;
      else if (w_byte && (r_rx_cnt != 3'd4))  r_rx_cnt <= r_rx_cnt + 3'd1;
    end
  end

`ifdef AHB_SPI_LOOPBACK_EN
  logic r_loop;

  always_ff @(posedge HCLK) begin
    if (HRESET)         r_loop <= 1'b0;
    else if (w_ctrl_wr) r_loop <= bus.HWDATA[ST_LOOP];
  end

  assign w_loop = r_loop;
  assign w_miso = r_loop ? SPI_MOSI_o : SPI_MISO_i;
`else
  assign w_loop = 1'b0;
  assign w_miso = SPI_MISO_i;
`endif

  spi_shifter u_shifter (
    .clk           (HCLK),
    .rst           (HRESET),
    .i_start       (w_start),
    .i_data        (bus.HWDATA),
    .i_nbytes      (r_nbytes),
    .i_miso        (w_miso),
    .o_sclk        (SPI_CLK_o),
    .o_mosi        (SPI_MOSI_o),
    .o_busy_c      (w_busy),
    .o_done_c      (w_done),
    .o_byte_done_c (w_byte),
    .o_rx          (w_rx)
  );

  assign SPI_SS_o = r_mode ? ~r_ss : r_ss;

  // Read data is live status, zero outside a read data phase
  always_comb begin
    w_rdata = '0;
    if (w_rd) begin
      case (r_dp_addr)
        A_CTRL: begin
          w_rdata[ST_NB_LSB +: 4] = {1'b0, r_nbytes};
          w_rdata[ST_LOOP]        = w_loop;
          w_rdata[ST_MODE]        = r_mode;
          w_rdata[ST_TX_DONE]     = r_done;
          w_rdata[ST_OVERRUN]     = r_overrun;
          w_rdata[ST_BUSY]        = w_busy;
          w_rdata[ST_RX_FULL]     = r_rx_full;
        end
        A_SS:    w_rdata = DATA_W'(r_ss);
        A_RX:    w_rdata = w_rx;
        default: w_rdata = '0;
      endcase
    end
  end

  assign bus.HRDATA    = w_rdata;
  assign bus.HREADYOUT = 1'b1;

endmodule

// File: tb/tb_ahb_spi.sv
// Self-checking bench for ahb_spi: directed sequence with randomized payloads and a frame-level model.
`timescale 1ns/1ps
module tb_ahb_spi;
  import ahb_spi_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              miso;
  logic              mosi;
  logic              sclk;
  logic [NUM_SS-1:0] ss;

  ahb_spi_if bus();

  ahb_spi dut (
    .HCLK       (clk),
    .HRESET     (rst),
    .bus        (bus.slave),
    .SPI_MISO_i (miso),
    .SPI_MOSI_o (mosi),
    .SPI_SS_o   (ss),
    .SPI_CLK_o  (sclk)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // SPI slave model: capture MOSI on rising SCLK, present next MISO bit after falling SCLK
  bit mosi_q[$];
  bit miso_q[$];
  always @(posedge sclk) mosi_q.push_back(mosi);
  always @(negedge sclk) if (miso_q.size() > 0) miso = miso_q.pop_front();

  // Reference model state
  int          m_n;
  bit          m_mode;
  bit          m_loop;
  bit          m_done;
  bit          m_ovr;
  int          m_rxcnt;
  logic [31:0] m_rx;
  logic [31:0] m_ss;

  function automatic logic [31:0] exp_ctrl(input bit busy);
    return {16'h0, 4'(m_n), 4'h0, m_loop, m_mode, 1'b0, m_done, 1'b0, m_ovr, busy, (m_rxcnt >= 4)};
  endfunction

  function automatic logic [31:0] exp_ss();
    return m_mode ? ~m_ss : m_ss;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic ahb_write(input logic [3:0] ofs, input logic [31:0] d);
    @(negedge clk);
    bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b1; bus.HADDR = {28'h0, ofs};
    @(negedge clk);
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HWRITE = 1'b0; bus.HWDATA = d;
  endtask

  task automatic ahb_read(input logic [3:0] ofs, output logic [31:0] d);
    @(negedge clk);
    bus.HSEL = 1'b1; bus.HTRANS = HTRANS_NONSEQ; bus.HWRITE = 1'b0; bus.HADDR = {28'h0, ofs};
    @(negedge clk);
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE;
    d = bus.HRDATA;
  endtask

  task automatic read_rx(input string tag);
    logic [31:0] rd;
    ahb_read(OFS_RX, rd);
    check(tag, rd, m_rx);
    m_done = 0; m_ovr = 0; m_rxcnt = 0;
    ahb_read(OFS_CTRL, rd);
    check({tag, "_status_cleared"}, rd, exp_ctrl(1'b0));
  endtask

  // One full frame: expected MOSI bits, SCLK timing, final status and RX contents
  task automatic run_frame(input logic [31:0] data, input logic [31:0] mw,
                           input bit ovr_inject, input bit inv_miso);
    int          n;
    logic [31:0] mask;
    logic [31:0] got;
    logic [31:0] rd;
    int unsigned t0;
    n    = m_n;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    mosi_q.delete();
    miso_q.delete();
    for (int i = 8 * n - 1; i >= 0; i--) miso_q.push_back(inv_miso ? ~mw[i] : mw[i]);
    miso = miso_q.pop_front();
    ahb_write(OFS_TX, data);
    t0 = cyc;
    m_done = 0;
    ahb_read(OFS_CTRL, rd);
    check("busy_during_frame", rd, exp_ctrl(1'b1));
    if (ovr_inject) begin
      ahb_write(OFS_TX, $urandom);
      m_ovr = 1;
    end
    while (cyc < t0 + 16 * n * CLK_DIV) @(negedge clk);
    check("sclk_high_before_last_fall", 32'(sclk), 32'd1);
    check("sclk_pulse_count", 32'(mosi_q.size()), 32'(8 * n));
    @(negedge clk);
    check("sclk_low_at_frame_end", 32'(sclk), 32'd0);
    got = '0;
    foreach (mosi_q[i]) got = {got[30:0], mosi_q[i]};
    check("mosi_stream", got, data & mask);
    m_rx    = 32'((64'(m_rx) << (8 * n)) | 64'(mw & mask));
    m_rxcnt = (m_rxcnt + n > 4) ? 4 : m_rxcnt + n;
    m_done  = 1;
    ahb_read(OFS_CTRL, rd);
    check("status_after_frame", rd, exp_ctrl(1'b0));
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  nf;
    bit          md;
    logic [31:0] ssv;

    rst = 1'b1; miso = 1'b0;
    bus.HSEL = 1'b0; bus.HTRANS = HTRANS_IDLE; bus.HWRITE = 1'b0; bus.HADDR = '0;
    bus.HSIZE = HSIZE_WORD; bus.HREADY = 1'b1; bus.HWDATA = '0;
    m_n = 4; m_mode = 1; m_loop = 0; m_done = 0; m_ovr = 0; m_rxcnt = 0; m_rx = '0; m_ss = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("reset_ss", ss, 32'hFFFF_FFFF);
    check("reset_sclk", 32'(sclk), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_hreadyout", 32'(bus.HREADYOUT), 32'd1);
    check("reset_hrdata", bus.HRDATA, 32'd0);
    ahb_read(OFS_CTRL, rd); check("reset_ctrl", rd, 32'h0000_4040);
    ahb_read(OFS_SS, rd);   check("reset_ss_reg", rd, 32'd0);
    ahb_read(OFS_RX, rd);   check("reset_rx", rd, 32'd0);

    ahb_write(OFS_CTRL, 32'h2040); m_n = 2; m_mode = 1;
    ahb_write(OFS_SS, 32'h1);      m_ss = 32'h1;
    @(negedge clk);
    check("ss_onehot_slave0", ss, 32'hFFFF_FFFE);

    run_frame(32'h1308, 32'h0102, 0, 0);
    run_frame($urandom, 32'h0304, 0, 0);
    read_rx("rx_four_bytes");
    check("rx_model_value", m_rx, 32'h0102_0304);

    run_frame($urandom, $urandom, 1, 0);
    read_rx("rx_after_overrun");

    for (int i = 0; i < 4; i++) begin
      nf  = (i == 0) ? 4'd0 : (i == 1) ? 4'd9 : 4'($urandom_range(1, 4));
      md  = 1'($urandom_range(0, 1));
      ahb_write(OFS_CTRL, {16'h0, nf, 4'h0, 1'b0, md, 6'h0});
      m_n = (nf == 0 || nf > 4) ? 4 : int'(nf);
      m_mode = md;
      ssv = $urandom;
      ahb_write(OFS_SS, ssv); m_ss = ssv;
      @(negedge clk);
      check("ss_random", ss, exp_ss());
      run_frame($urandom, $urandom, 0, 0);
      if (i % 2 == 1) read_rx("rx_random");
    end

    ahb_write(OFS_CTRL, 32'h1000); m_n = 1; m_mode = 0;
    ahb_write(OFS_SS, 32'hFFFF_FFFE); m_ss = 32'hFFFF_FFFE;
    @(negedge clk);
    check("ss_mode0_direct", ss, 32'hFFFF_FFFE);

    ahb_write(OFS_TX, $urandom);
    repeat (CLK_DIV + 2) @(negedge clk);
    check("sclk_high_mid_frame", 32'(sclk), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_mosi", 32'(mosi), 32'd0);
    check("abort_ss", ss, 32'hFFFF_FFFF);
    m_n = 4; m_mode = 1; m_loop = 0; m_done = 0; m_ovr = 0; m_rxcnt = 0; m_rx = '0; m_ss = '0;
    ahb_read(OFS_CTRL, rd); check("abort_ctrl", rd, 32'h0000_4040);
    ahb_read(OFS_RX, rd);   check("abort_rx", rd, 32'd0);

`ifdef AHB_SPI_LOOPBACK_EN
    ahb_write(OFS_CTRL, 32'h40C0); m_n = 4; m_mode = 1; m_loop = 1;
    run_frame(32'hA5C3_3C5A, 32'hA5C3_3C5A, 0, 1);
    read_rx("rx_loopback");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
